// File: rtl/pio_arbiter.sv
// pio_arbiter -- two-requester Avalon-MM arbiter in front of a single PIO slave.
//
// Two requesters (s0, s1) compete for one downstream master port (m_*).
// IDLE picks a winner (round-robin when both ask), BUSY forwards the winner's
// request combinationally until the slave drops waitrequest or the winner
// withdraws its request.
//
// Optional feature (compile-time macro PIO_ARB_TIMEOUT_EN):
//   undefined : BUSY waits forever on m_waitrequest, timeout_err tied to 0.
//   defined   : after TIMEOUT_CYCLES stalled BUSY cycles the transfer is
//               force-completed with readdata 0xDEADBEEF and timeout_err sets
//               (sticky until reset).
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   sN_address/read/write/
//   sN_writedata                 requester N request
//   sN_readdata, sN_waitrequest  requester N response
//   m_address/read/write/
//   m_writedata                  request to the PIO slave
//   m_readdata, m_waitrequest    PIO slave response
//   grant                        current or last granted requester index
//   timeout_err                  sticky downstream-timeout flag
module pio_arbiter #(
  parameter int ADDR_W         = 2,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] s0_address,
  input  logic              s0_read,
  input  logic              s0_write,
  input  logic [DATA_W-1:0] s0_writedata,
  output logic [DATA_W-1:0] s0_readdata,
  output logic              s0_waitrequest,
  input  logic [ADDR_W-1:0] s1_address,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [DATA_W-1:0] s1_writedata,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_waitrequest,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_waitrequest,
  output logic              grant,
  output logic              timeout_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t r_state;
  logic   r_grant;
  logic   r_terr;

  logic              w_req0, w_req1, w_busy;
  logic              w_sel_rd, w_sel_wr, w_sel_req;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wd, w_rd;
  logic              w_wait, w_tmo;

  assign w_req0 = s0_read | s0_write;
  assign w_req1 = s1_read | s1_write;
  assign w_busy = (r_state == BUSY);

  // Granted requester's request, selected by the registered grant.
  assign w_sel_rd   = r_grant ? s1_read      : s0_read;
  assign w_sel_wr   = r_grant ? s1_write     : s0_write;
  assign w_sel_addr = r_grant ? s1_address   : s0_address;
  assign w_sel_wd   = r_grant ? s1_writedata : s0_writedata;
  assign w_sel_req  = w_sel_rd | w_sel_wr;

`ifdef PIO_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] r_cnt;
  // Forced completion: stall still pending and the budget is exhausted.
  assign w_tmo = w_busy & w_sel_req & m_waitrequest & (r_cnt == TMO_VAL);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
  assign w_tmo        = 1'b0;
`endif

  // Master side: mirrors the winner in BUSY, quiet in IDLE. Write wins over read.
  assign m_read      = w_busy & w_sel_rd & ~w_sel_wr;
  assign m_write     = w_busy & w_sel_wr;
  assign m_address   = w_busy ? w_sel_addr : '0;
  assign m_writedata = w_busy ? w_sel_wd   : '0;

  assign w_wait = m_waitrequest & ~w_tmo;
  assign w_rd   = w_tmo ? DATA_W'(32'hDEADBEEF) : m_readdata;

  // Only the granted port in BUSY sees the slave; everyone else is stalled.
  assign s0_waitrequest = (w_busy & ~r_grant) ? w_wait : 1'b1;
  assign s1_waitrequest = (w_busy &  r_grant) ? w_wait : 1'b1;
  assign s0_readdata    = (w_busy & ~r_grant) ? w_rd   : '0;
  assign s1_readdata    = (w_busy &  r_grant) ? w_rd   : '0;

  assign grant       = r_grant;
  assign timeout_err = r_terr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_grant <= 1'b1;   // s0 wins the first contest
      r_terr  <= 1'b0;
`ifdef PIO_ARB_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req0 | w_req1) begin
            r_state <= BUSY;
            // Contest: the port that did not win last time takes it.
            r_grant <= (w_req0 & w_req1) ? ~r_grant : w_req1;
`ifdef PIO_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        BUSY: begin
          // Exit on completion, forced completion, or withdrawn request.
          if (!w_sel_req || !m_waitrequest || w_tmo) begin
            r_state <= IDLE;
            if (w_tmo) r_terr <= 1'b1;
          end
`ifdef PIO_ARB_TIMEOUT_EN
          else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pio_arbiter.md
PIO_ARBITER -- requirements
Module: pio_arbiter

Interface
REQ-001 Parameter ADDR_W, default 2, address width of all Avalon-MM ports.
REQ-002 Parameter DATA_W, default 32, data width of all Avalon-MM ports.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, waitrequest cycles before abort (used only with the REQ-030 macro defined).
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 s0_address / s1_address  in  ADDR_W  requester N address.
REQ-007 s0_read / s1_read  in  1  requester N read request.
REQ-008 s0_write / s1_write  in  1  requester N write request.
REQ-009 s0_writedata / s1_writedata  in  DATA_W  requester N write data.
REQ-010 s0_readdata / s1_readdata  out  DATA_W  requester N read data.
REQ-011 s0_waitrequest / s1_waitrequest  out  1  requester N stall.
REQ-012 m_address  out  ADDR_W, m_read  out  1, m_write  out  1, m_writedata  out  DATA_W  master request to the PIO slave.
REQ-013 m_readdata  in  DATA_W, m_waitrequest  in  1  PIO slave response.
REQ-014 grant  out  1  index of the current or last granted requester.
REQ-015 timeout_err  out  1  sticky downstream-timeout flag.

Function
REQ-016 States: IDLE, BUSY; sN request = sN_read | sN_write; write takes precedence when both are asserted.
REQ-017 In IDLE, a single requester is granted; with both requesting, the requester other than grant wins (round-robin); IDLE->BUSY on the next edge.
REQ-018 In BUSY, m_address/m_writedata/m_read/m_write mirror the granted requester combinationally; all m_* outputs are 0 in IDLE.
REQ-019 Granted sN_waitrequest = m_waitrequest in BUSY; it is 1 in all other cases, including the non-granted port and IDLE.
REQ-020 sN_readdata = m_readdata while sN is granted, else 0.
REQ-021 Completion occurs in a BUSY cycle with m_waitrequest=0; the next state is IDLE; minimum request-to-completion latency is 1 cycle; back-to-back transfers from one requester take 2 cycles each.
REQ-022 Granted requester dropping its request in BUSY -> IDLE next edge, no completion; grant is unchanged.
REQ-023 A non-granted requester is never starved: after a completion it wins the next arbitration if requesting.
REQ-024 A new request arriving while in BUSY is not considered until the FSM returns to IDLE.

Reset
REQ-025 reset_n=0 at an edge -> state IDLE, grant=1 (s0 wins the first contest), timeout counter=0, timeout_err=0.
REQ-026 Reset during BUSY abandons the transfer; m_read/m_write are 0 from the cycle after the edge.
REQ-027 No output depends on reset_n combinationally.

Configuration
REQ-028 Macro PIO_ARB_TIMEOUT_EN selects the downstream-timeout feature.
REQ-029 Undefined: BUSY waits indefinitely on m_waitrequest; timeout_err is tied to 0.
REQ-030 Defined: an 8+ bit counter increments each BUSY cycle with m_waitrequest=1 and clears on entering BUSY.
REQ-031 Defined: at count == TIMEOUT_CYCLES, the requester completes that cycle with waitrequest=0 and readdata=32'hDEADBEEF truncated to DATA_W; the FSM then goes to IDLE and timeout_err is set until reset.

Verification
REQ-032 s0 writes addr 0 data 0x5A, m_waitrequest=0 -> m_write=1, m_writedata=0x5A one cycle after request; s0_waitrequest=0 that cycle.
REQ-033 s0 and s1 read simultaneously from reset -> s0 served first, then s1; grant sequence 0,1; s1_waitrequest=1 throughout the s0 transfer.
REQ-034 s1 reads, m_readdata=0x3C, m_waitrequest=1 for 3 cycles -> s1_readdata=0x3C on completion; latency 4 cycles; s0_readdata=0.
REQ-035 reset_n=0 mid-BUSY -> m_write=0 and grant=1 the next cycle; no completion reported to the requester.
REQ-036 With PIO_ARB_TIMEOUT_EN and m_waitrequest stuck at 1 -> completion after 255 stall cycles, readdata=0xDEADBEEF, timeout_err=1 until reset.
